// File: rtl/serial_parity_framer_pkg.sv
// Shared types and constants for the serial parity framer.
package serial_parity_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DATA = 2'd1,
        S_PAR  = 2'd2
    } state_e;

    localparam logic MODE_GEN = 1'b0;
    localparam logic MODE_CHK = 1'b1;

endpackage

// File: rtl/parity_toggle_cell.sv
// Single-bit parity accumulator: loads a start value, toggles on each 1, holds on 0.
module parity_toggle_cell #(
    parameter logic INIT = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic load_val,
    input  logic toggle,
    output logic q
);

    logic p_d;
    logic p_q;

    always_comb begin
        p_d = p_q;
        if (load) begin
            p_d = load_val;
        end else if (toggle) begin
            p_d = ~p_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            p_q <= INIT;
        end else begin
            p_q <= p_d;
        end
    end

    assign q = p_q;

endmodule

// File: rtl/serial_parity_framer.sv
// Frames a qualified serial bitstream into WORD_W-bit words and generates or checks parity.
module serial_parity_framer
    import serial_parity_pkg::*;
#(
    parameter int WORD_W = 8,
    parameter bit ODD    = 1'b0,
    parameter int CNT_W  = 8,
    parameter int BC_W   = $clog2(WORD_W + 1)
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             D_in,
    input  logic             D_valid,
    input  logic             check_en,
    input  logic             clr_err,
    output logic             P_run,
    output logic [BC_W-1:0]  bit_cnt,
    output logic             busy,
    output logic             frame_done,
    output logic             parity_out,
    output logic             parity_err,
    output logic [CNT_W-1:0] err_cnt
);

    localparam logic [BC_W-1:0]  LAST_CNT = BC_W'(WORD_W - 1);
    localparam logic [BC_W-1:0]  FULL_CNT = BC_W'(WORD_W);
    localparam logic [BC_W-1:0]  ONE_CNT  = BC_W'(1);
    localparam logic [CNT_W-1:0] ERR_MAX  = {CNT_W{1'b1}};

    state_e           state_d, state_q;
    logic [BC_W-1:0]  bit_cnt_d, bit_cnt_q;
    logic             mode_d, mode_q;
    logic             busy_d, busy_q;
    logic             frame_done_d, frame_done_q;
    logic             parity_out_d, parity_out_q;
    logic             parity_err_d, parity_err_q;
    logic [CNT_W-1:0] err_cnt_d, err_cnt_q;
    logic             set_err;
    logic             p_load;
    logic             p_toggle;
    logic             p_run;

    parity_toggle_cell #(
        .INIT (ODD)
    ) u_parity (
        .clk      (CLK),
        .reset    (reset),
        .load     (p_load),
        .load_val (ODD ^ D_in),
        .toggle   (p_toggle),
        .q        (p_run)
    );

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        mode_d       = mode_q;
        frame_done_d = 1'b0;
        parity_out_d = parity_out_q;
        parity_err_d = parity_err_q;
        set_err      = 1'b0;
        p_load       = 1'b0;
        p_toggle     = 1'b0;
        if (D_valid) begin
            case (state_q)
                S_IDLE: begin
                    state_d   = S_DATA;
                    bit_cnt_d = ONE_CNT;
                    mode_d    = check_en;
                    p_load    = 1'b1;
                end
                S_DATA: begin
                    p_toggle = D_in;
                    if (bit_cnt_q == LAST_CNT) begin
                        if (mode_q == MODE_CHK) begin
                            state_d   = S_PAR;
                            bit_cnt_d = FULL_CNT;
                        end else begin
                            state_d      = S_IDLE;
                            bit_cnt_d    = '0;
                            frame_done_d = 1'b1;
                            parity_out_d = p_run ^ D_in;
                            parity_err_d = 1'b0;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + ONE_CNT;
                    end
                end
                S_PAR: begin
                    // The received parity bit is compared, never folded into P_run.
                    state_d      = S_IDLE;
                    bit_cnt_d    = '0;
                    frame_done_d = 1'b1;
                    parity_out_d = p_run;
                    parity_err_d = (D_in != p_run);
                    set_err      = (D_in != p_run);
                end
                default: begin
                    state_d   = S_IDLE;
                    bit_cnt_d = '0;
                end
            endcase
        end
        busy_d = (state_d != S_IDLE);
    end

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (clr_err) begin
            err_cnt_d = '0;
        end else if (set_err && (err_cnt_q != ERR_MAX)) begin
            err_cnt_d = err_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            bit_cnt_q    <= '0;
            mode_q       <= MODE_GEN;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            parity_out_q <= ODD;
            parity_err_q <= 1'b0;
            err_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            mode_q       <= mode_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            parity_out_q <= parity_out_d;
            parity_err_q <= parity_err_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign P_run      = p_run;
    assign bit_cnt    = bit_cnt_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign parity_out = parity_out_q;
    assign parity_err = parity_err_q;
    assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_serial_parity_framer.sv
// Scoreboard bench for serial_parity_framer (WORD_W=8, CNT_W=2; even and odd instances).
module tb_serial_parity_framer;

    typedef struct packed {
        logic       par;
        logic       err;
        logic [1:0] cnt;
    } exp_t;

    logic       clk;
    logic       reset;
    logic       D_in;
    logic       D_valid;
    logic       check_en;
    logic       clr_err;

    logic       P_run, busy, frame_done, parity_out, parity_err;
    logic [3:0] bit_cnt;
    logic [1:0] err_cnt;

    logic       oddPRun, oddBusy, oddFrameDone, oddParityOut, oddParityErr;
    logic [3:0] oddBitCnt;
    logic [1:0] oddErrCnt;

    int   checkCount = 0;
    int   errCount   = 0;
    bit   monOn      = 1'b0;
    exp_t expQ[$];

    int   mState = 0;
    int   mCnt   = 0;
    logic mP     = 1'b0;
    logic mMode  = 1'b0;
    int   mErr   = 0;

    serial_parity_framer #(.WORD_W(8), .ODD(1'b0), .CNT_W(2)) dut (
        .CLK(clk), .reset(reset), .D_in(D_in), .D_valid(D_valid),
        .check_en(check_en), .clr_err(clr_err), .P_run(P_run), .bit_cnt(bit_cnt),
        .busy(busy), .frame_done(frame_done), .parity_out(parity_out),
        .parity_err(parity_err), .err_cnt(err_cnt)
    );

    serial_parity_framer #(.WORD_W(8), .ODD(1'b1), .CNT_W(2)) dutOdd (
        .CLK(clk), .reset(reset), .D_in(D_in), .D_valid(D_valid),
        .check_en(check_en), .clr_err(clr_err), .P_run(oddPRun), .bit_cnt(oddBitCnt),
        .busy(oddBusy), .frame_done(oddFrameDone), .parity_out(oddParityOut),
        .parity_err(oddParityErr), .err_cnt(oddErrCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, actual, expected, $time);
        end
    endtask

    // Drives one cycle of inputs and advances the reference model on the same edge.
    task automatic applyStimulus(input logic rstN, input logic valid, input logic d,
                                 input logic chk, input logic clr);
        logic errSet;
        logic doPush;
        logic pushErr;
        @(negedge clk);
        reset    = rstN;
        D_valid  = valid;
        D_in     = d;
        check_en = chk;
        clr_err  = clr;
        @(posedge clk);
        errSet  = 1'b0;
        doPush  = 1'b0;
        pushErr = 1'b0;
        if (!rstN) begin
            mState = 0; mCnt = 0; mP = 1'b0; mErr = 0;
        end else begin
            if (valid) begin
                case (mState)
                    0: begin
                        mMode = chk; mP = d; mCnt = 1; mState = 1;
                    end
                    1: begin
                        mP = mP ^ d;
                        if (mCnt == 7) begin
                            if (mMode) begin
                                mState = 2; mCnt = 8;
                            end else begin
                                mState = 0; mCnt = 0; doPush = 1'b1;
                            end
                        end else begin
                            mCnt++;
                        end
                    end
                    default: begin
                        errSet = (d != mP); pushErr = errSet; doPush = 1'b1;
                        mState = 0; mCnt = 0;
                    end
                endcase
            end
            if (clr) mErr = 0;
            else if (errSet && mErr != 3) mErr++;
            if (doPush) expQ.push_back('{par: mP, err: pushErr, cnt: 2'(mErr)});
        end
    endtask

    task automatic sendData(input logic [7:0] bits, input logic chkFirst,
                            input logic chkRest, input int gapMax);
        for (int i = 7; i >= 0; i--) begin
            applyStimulus(1'b1, 1'b1, bits[i], (i == 7) ? chkFirst : chkRest, 1'b0);
            if (gapMax > 0 && i > 0) begin
                repeat ($urandom_range(1, gapMax)) applyStimulus(1'b1, 1'b0, 1'b0, chkRest, 1'b0);
            end
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (monOn) begin
            checkOutput("p_run", P_run, mP);
            checkOutput("bit_cnt", bit_cnt, mCnt);
            checkOutput("busy", busy, mState != 0);
            checkOutput("err_cnt", err_cnt, mErr);
            if (frame_done === 1'b1) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_done", frame_done, 0);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("parity_out", parity_out, e.par);
                    checkOutput("parity_err", parity_err, e.err);
                    checkOutput("done_err_cnt", err_cnt, e.cnt);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        reset = 1'b0; D_valid = 1'b0; D_in = 1'b0; check_en = 1'b0; clr_err = 1'b0;

        // Reset held across edges with activity on the inputs.
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        checkOutput("rst_p_run", P_run, 0);
        checkOutput("rst_bit_cnt", bit_cnt, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", frame_done, 0);
        checkOutput("rst_parity_out", parity_out, 0);
        checkOutput("rst_parity_err", parity_err, 0);
        checkOutput("rst_err_cnt", err_cnt, 0);
        checkOutput("rst_odd_p_run", oddPRun, 1);
        checkOutput("rst_odd_parity_out", oddParityOut, 1);
        checkOutput("rst_odd_busy", oddBusy, 0);
        monOn = 1'b1;

        // Generate mode, back-to-back frames.
        sendData(8'b10110010, 1'b0, 1'b0, 0);
        #1;
        checkOutput("gen_done_latency", frame_done, 1);
        checkOutput("gen_parity_a", parity_out, 0);
        checkOutput("odd_done", oddFrameDone, 1);
        checkOutput("odd_parity_a", oddParityOut, 1);
        sendData(8'b00000001, 1'b0, 1'b0, 0);
        #1;
        checkOutput("gen_parity_b", parity_out, 1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // Same frame with idle gaps between bits.
        sendData(8'b10110010, 1'b0, 1'b0, 3);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // Check mode: good parity, bad parity, and check_en dropped mid-frame.
        sendData(8'b11100000, 1'b1, 1'b1, 0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        sendData(8'b11100000, 1'b1, 1'b1, 0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        sendData(8'b11100000, 1'b1, 1'b0, 0);
        #1;
        checkOutput("chk_still_busy", busy, 1);
        checkOutput("chk_par_cnt", bit_cnt, 8);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // Mid-frame reset aborts the frame.
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        #1;
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_bit_cnt", bit_cnt, 0);
        checkOutput("abort_no_done", frame_done, 0);
        repeat (2) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset pulse between edges only is ignored.
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        #2 reset = 1'b0;
        #2 reset = 1'b1;
        #3;
        checkOutput("glitch_bit_cnt", bit_cnt, 3);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // Saturating error count, then clear winning over a same-edge error.
        for (int f = 0; f < 5; f++) begin
            sendData(8'b11100000, 1'b1, 1'b1, 0);
            applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        end
        #1;
        checkOutput("err_saturated", err_cnt, 3);
        sendData(8'b11100000, 1'b1, 1'b1, 0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        #1;
        checkOutput("clr_err_cnt", err_cnt, 0);
        checkOutput("clr_parity_err", parity_err, 1);
        repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        checkOutput("pending_frames", expQ.size(), 0);
        monOn = 1'b0;
        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
